// File: rtl/axis_eth_fcs_pad.sv
// Ethernet TX framing stage: zero-pads short frames to MIN_LEN and appends the
// IEEE 802.3 CRC-32 FCS behind a single output register stage.
//
// state   | meaning
// --------+------------------------------------------
// IDLE    | no frame in progress
// PAYLOAD | forwarding input bytes
// PAD     | emitting 0x00 pad bytes up to MIN_LEN
// FCS     | emitting the 4 FCS bytes, LSB first
module axis_eth_fcs_pad #(
    parameter int MIN_LEN = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    input  logic       s_axis_tlast,
    input  logic       s_axis_tuser,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       m_axis_tlast,
    output logic       m_axis_tuser,
    output logic       stat_frame_o,
    output logic       stat_pad_o,
    output logic       stat_bad_o
);

    typedef enum logic [1:0] {IDLE, PAYLOAD, PAD, FCS} state_t;

    localparam logic [15:0] MIN_LEN_W = 16'(MIN_LEN);

    state_t      state_q, state_d;
    logic [31:0] crc_q, crc_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic        bad_q, bad_d;
    logic        padded_q, padded_d;
    logic [7:0]  tdata_d;
    logic        tvalid_d, tlast_d, tuser_d;

    logic        load;
    logic [15:0] cnt_inc;
    logic        short_frame;
    logic [31:0] fcs_word;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        end
        return r;
    endfunction

    assign load          = !m_axis_tvalid || m_axis_tready;
    assign s_axis_tready = load && (state_q == IDLE || state_q == PAYLOAD);
    assign cnt_inc       = (&cnt_q) ? cnt_q : cnt_q + 16'd1;
    // cnt_inc < MIN_LEN, written so that MIN_LEN = 0 is not a constant compare
    assign short_frame   = ({1'b0, cnt_inc} + 17'd1) <= {1'b0, MIN_LEN_W};
    assign fcs_word      = bad_q ? crc_q : ~crc_q;

    assign stat_frame_o = m_axis_tvalid && m_axis_tready && m_axis_tlast;
    assign stat_pad_o   = stat_frame_o && padded_q;
    assign stat_bad_o   = stat_frame_o && bad_q;

    always_comb begin
        state_d  = state_q;
        crc_d    = crc_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        bad_d    = bad_q;
        padded_d = padded_q;
        tdata_d  = m_axis_tdata;
        tvalid_d = m_axis_tvalid;
        tlast_d  = m_axis_tlast;
        tuser_d  = m_axis_tuser;
        if (load) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            tuser_d  = 1'b0;
            case (state_q)
                IDLE, PAYLOAD: begin
                    if (s_axis_tvalid) begin
                        tdata_d  = s_axis_tdata;
                        tvalid_d = 1'b1;
                        crc_d    = crc_byte(crc_q, s_axis_tdata);
                        cnt_d    = cnt_inc;
                        state_d  = PAYLOAD;
                        if (s_axis_tlast) begin
                            bad_d    = s_axis_tuser;
                            padded_d = short_frame;
                            idx_d    = 2'd0;
                            state_d  = short_frame ? PAD : FCS;
                        end
                    end
                end
                PAD: begin
                    tdata_d  = 8'h00;
                    tvalid_d = 1'b1;
                    crc_d    = crc_byte(crc_q, 8'h00);
                    cnt_d    = cnt_inc;
                    if (cnt_inc == MIN_LEN_W) begin
                        state_d = FCS;
                    end
                end
                FCS: begin
                    tdata_d  = fcs_word[{idx_q, 3'b000} +: 8];
                    tvalid_d = 1'b1;
                    if (idx_q == 2'd3) begin
                        tlast_d = 1'b1;
                        tuser_d = bad_q;
                        state_d = IDLE;
                        crc_d   = 32'hFFFF_FFFF;
                        cnt_d   = 16'd0;
                        idx_d   = 2'd0;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            crc_q         <= 32'hFFFF_FFFF;
            cnt_q         <= 16'd0;
            idx_q         <= 2'd0;
            bad_q         <= 1'b0;
            padded_q      <= 1'b0;
            m_axis_tdata  <= 8'h00;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
        end else begin
            state_q       <= state_d;
            crc_q         <= crc_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            bad_q         <= bad_d;
            padded_q      <= padded_d;
            m_axis_tdata  <= tdata_d;
            m_axis_tvalid <= tvalid_d;
            m_axis_tlast  <= tlast_d;
            m_axis_tuser  <= tuser_d;
        end
    end

endmodule

// File: tb/tb_axis_eth_fcs_pad.sv
// Bench for axis_eth_fcs_pad: a MIN_LEN=0 instance for the CRC check string and a
// MIN_LEN=60 instance for padding, bad frames, backpressure and reset cases.
module tb_axis_eth_fcs_pad;

    typedef struct packed {
        logic       last;
        logic       user;
        logic [7:0] d;
    } beat_t;

    typedef struct {
        int len;
        bit bad;
        int exp_beats;
        bit exp_pad;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // MIN_LEN = 60 instance
    logic [7:0] s_tdata = '0;
    logic       s_tvalid = 1'b0, s_tlast = 1'b0, s_tuser = 1'b0, s_tready;
    logic [7:0] m_tdata;
    logic       m_tvalid, m_tlast, m_tuser;
    logic       m_tready = 1'b1;
    logic       st_frame, st_pad, st_bad;

    // MIN_LEN = 0 instance
    logic [7:0] s0_tdata = '0;
    logic       s0_tvalid = 1'b0, s0_tlast = 1'b0, s0_tuser = 1'b0, s0_tready;
    logic [7:0] m0_tdata;
    logic       m0_tvalid, m0_tlast, m0_tuser;
    logic       m0_tready = 1'b1;
    logic       st0_frame, st0_pad, st0_bad;

    axis_eth_fcs_pad #(.MIN_LEN(60)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
        .stat_frame_o(st_frame), .stat_pad_o(st_pad), .stat_bad_o(st_bad)
    );

    axis_eth_fcs_pad #(.MIN_LEN(0)) dut0 (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s0_tdata), .s_axis_tvalid(s0_tvalid), .s_axis_tready(s0_tready),
        .s_axis_tlast(s0_tlast), .s_axis_tuser(s0_tuser),
        .m_axis_tdata(m0_tdata), .m_axis_tvalid(m0_tvalid), .m_axis_tready(m0_tready),
        .m_axis_tlast(m0_tlast), .m_axis_tuser(m0_tuser),
        .stat_frame_o(st0_frame), .stat_pad_o(st0_pad), .stat_bad_o(st0_bad)
    );

    int errors = 0;
    int checks = 0;

    beat_t      out_q[$];
    beat_t      exp_q[$];
    logic [7:0] tx_q[$];
    int lasts = 0, frames = 0, pads = 0, bads = 0;
    beat_t out0_q[$];
    int frames0 = 0, pads0 = 0;
    bit rand_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // bit-serial reflected CRC-32
    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        logic fb;
        r = c;
        for (int k = 0; k < 8; k++) begin
            fb = r[0] ^ b[k];
            r  = r >> 1;
            if (fb) r = r ^ 32'hEDB8_8320;
        end
        return r;
    endfunction

    task automatic model_frame(input bit bad, input int min_len);
        logic [31:0] c;
        logic [31:0] fcs;
        c = 32'hFFFF_FFFF;
        foreach (tx_q[i]) begin
            exp_q.push_back('{1'b0, 1'b0, tx_q[i]});
            c = crc_upd(c, tx_q[i]);
        end
        for (int i = tx_q.size(); i < min_len; i++) begin
            exp_q.push_back('{1'b0, 1'b0, 8'h00});
            c = crc_upd(c, 8'h00);
        end
        fcs = bad ? c : ~c;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back('{k == 3, (k == 3) && bad, fcs[8*k +: 8]});
        end
    endtask

    task automatic check_stream(input string name);
        int    n;
        int    bad_i;
        beat_t a, e;
        checks++;
        n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
        bad_i = -1;
        for (int i = 0; i < n; i++) begin
            if (bad_i < 0 && out_q[i] !== exp_q[i]) bad_i = i;
        end
        if (bad_i < 0 && out_q.size() != exp_q.size()) bad_i = n;
        if (bad_i >= 0) begin
            errors++;
            a = (bad_i < out_q.size()) ? out_q[bad_i] : '0;
            e = (bad_i < exp_q.size()) ? exp_q[bad_i] : '0;
            $display("FAIL %s: beat %0d got {last,user,data}=%h expected %h (%0d beats, expected %0d)",
                     name, bad_i, a, e, out_q.size(), exp_q.size());
        end
    endtask

    task automatic clear_obs();
        out_q.delete();
        exp_q.delete();
        lasts = 0; frames = 0; pads = 0; bads = 0;
    endtask

    task automatic wait_accept(output bit ok);
        bit hs;
        ok = 1'b0;
        for (int t = 0; t < 5000; t++) begin
            @(negedge clk);
            hs = s_tready;
            @(posedge clk);
            #1;
            if (hs) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: s_axis_tready never rose, got 0 expected 1");
        end
    endtask

    task automatic send_frame(input bit bad, input bit gaps, input int limit);
        bit ok;
        int n;
        n = tx_q.size();
        for (int i = 0; i < n && i < limit; i++) begin
            if (gaps && $urandom_range(0, 4) == 0) begin
                s_tvalid = 1'b0;
                repeat ($urandom_range(1, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            s_tvalid = 1'b1;
            s_tdata  = tx_q[i];
            s_tlast  = (i == n - 1);
            s_tuser  = (i == n - 1) && bad;
            wait_accept(ok);
            if (!ok) break;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
    endtask

    task automatic wait_lasts(input int target, input int budget);
        for (int t = 0; t < budget && lasts < target; t++) @(posedge clk);
        check("frame_done", 32'(lasts), 32'(target));
    endtask

    // Output monitor for the MIN_LEN=60 instance, with stall-stability checks
    initial begin
        bit    stalled;
        beat_t held;
        stalled = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    check("stall_hold", {m_tvalid, m_tlast, m_tuser, m_tdata},
                          {1'b1, held.last, held.user, held.d});
                end
                if (m_tvalid && m_tready) begin
                    out_q.push_back('{m_tlast, m_tuser, m_tdata});
                    if (m_tlast) lasts++;
                end
                if (st_frame) frames++;
                if (st_pad)   pads++;
                if (st_bad)   bads++;
                stalled = m_tvalid && !m_tready;
                held = '{m_tlast, m_tuser, m_tdata};
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (m0_tvalid && m0_tready) out0_q.push_back('{m0_tlast, m0_tuser, m0_tdata});
                if (st0_frame) frames0++;
                if (st0_pad)   pads0++;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        vec_t       vecs[6];
        logic [7:0] exp0[13];
        int         exp_pads, exp_bads, len, mism;
        bit         bad;

        vecs[0] = '{len: 1,  bad: 1'b0, exp_beats: 64, exp_pad: 1'b1};
        vecs[1] = '{len: 60, bad: 1'b0, exp_beats: 64, exp_pad: 1'b0};
        vecs[2] = '{len: 61, bad: 1'b0, exp_beats: 65, exp_pad: 1'b0};
        vecs[3] = '{len: 64, bad: 1'b1, exp_beats: 68, exp_pad: 1'b0};
        vecs[4] = '{len: 59, bad: 1'b0, exp_beats: 64, exp_pad: 1'b1};
        vecs[5] = '{len: 2,  bad: 1'b1, exp_beats: 64, exp_pad: 1'b1};
        exp0 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                 8'h26, 8'h39, 8'hF4, 8'hCB};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_m_tvalid", m_tvalid, 1'b0);
        check("rst_m_tdata", m_tdata, 8'h00);
        check("rst_m_tlast", m_tlast, 1'b0);
        check("rst_m_tuser", m_tuser, 1'b0);
        check("rst_stats", {st_frame, st_pad, st_bad}, 3'b000);
        check("rst_s_tready", s_tready, 1'b1);
        @(posedge clk);
        #1;

        // "123456789" through the MIN_LEN=0 instance, one byte per cycle
        for (int i = 0; i < 9; i++) begin
            s0_tdata  = 8'(8'h31 + i);
            s0_tvalid = 1'b1;
            s0_tlast  = (i == 8);
            @(posedge clk);
            #1;
            if (i == 0) begin
                check("latency_valid", m0_tvalid, 1'b1);
                check("latency_data", m0_tdata, 8'h31);
            end
        end
        s0_tvalid = 1'b0;
        s0_tlast  = 1'b0;
        repeat (10) @(posedge clk);
        check("crc_string_beats", 32'(out0_q.size()), 32'd13);
        mism = 0;
        for (int i = 0; i < 13 && i < out0_q.size(); i++) begin
            if (out0_q[i] !== {(i == 12), 1'b0, exp0[i]}) mism++;
        end
        check("crc_string_data_mismatches", 32'(mism), 32'd0);
        check("crc_string_stat_frame", 32'(frames0), 32'd1);
        check("crc_string_stat_pad", 32'(pads0), 32'd0);
        #1;

        foreach (vecs[v]) begin
            clear_obs();
            tx_q.delete();
            for (int i = 0; i < vecs[v].len; i++) tx_q.push_back(8'(8'hAB + 3 * i));
            model_frame(vecs[v].bad, 60);
            send_frame(vecs[v].bad, 1'b0, vecs[v].len);
            wait_lasts(1, 300);
            check($sformatf("vec%0d_beats", v), 32'(out_q.size()), 32'(vecs[v].exp_beats));
            check_stream($sformatf("vec%0d_stream", v));
            check($sformatf("vec%0d_stat_frame", v), 32'(frames), 32'd1);
            check($sformatf("vec%0d_stat_pad", v), 32'(pads), 32'(vecs[v].exp_pad));
            check($sformatf("vec%0d_stat_bad", v), 32'(bads), 32'(vecs[v].bad));
            @(posedge clk);
            #1;
        end

        // reset in the middle of a 100-byte frame
        clear_obs();
        tx_q.delete();
        for (int i = 0; i < 100; i++) tx_q.push_back(8'(i + 1));
        send_frame(1'b0, 1'b0, 30);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("midrst_m_tvalid", m_tvalid, 1'b0);
        check("midrst_no_tlast", 32'(lasts), 32'd0);
        check("midrst_no_stat", 32'(frames), 32'd0);
        clear_obs();
        tx_q.delete();
        for (int i = 0; i < 64; i++) tx_q.push_back(8'(8'hC0 ^ i));
        model_frame(1'b0, 60);
        send_frame(1'b0, 1'b0, 64);
        wait_lasts(1, 300);
        check_stream("after_rst_stream");
        @(posedge clk);
        #1;

        // random backpressure and input gaps
        clear_obs();
        rand_ready = 1'b1;
        exp_pads = 0;
        exp_bads = 0;
        for (int f = 0; f < 200; f++) begin
            len = (f % 67 == 66) ? 1518 : $urandom_range(1, 64);
            bad = ($urandom_range(0, 7) == 0);
            tx_q.delete();
            for (int i = 0; i < len; i++) tx_q.push_back(8'($urandom_range(0, 255)));
            model_frame(bad, 60);
            if (len < 60) exp_pads++;
            if (bad) exp_bads++;
            send_frame(bad, 1'b1, len);
        end
        wait_lasts(200, 2000);
        rand_ready = 1'b0;
        repeat (4) @(posedge clk);
        check_stream("random_stream");
        check("random_tlast_count", 32'(lasts), 32'd200);
        check("random_stat_frame", 32'(frames), 32'd200);
        check("random_stat_pad", 32'(pads), 32'(exp_pads));
        check("random_stat_bad", 32'(bads), 32'(exp_bads));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
